// File: rtl/map_ram_arbiter_if.sv
// Game-logic access bus for the tile-map RAM arbiter.
// master = game logic, slave = arbiter.
interface map_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 3
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid, err
  );

endinterface

// File: rtl/map_ram_arbiter.sv
// Shares the single-port synchronous-read tile-map RAM between the VGA tile prefetch
// and game-logic accesses; display prefetch slots always win.
module map_ram_arbiter #(
  parameter int unsigned TILE_SHIFT = 5,
  parameter int unsigned MAP_W      = 20,
  parameter int unsigned MAP_H      = 15,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  output logic [DATA_W-1:0]   tile_cur,
  map_ram_arbiter_if.slave    game,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned MapSize = MAP_W * MAP_H;
  localparam logic [TILE_SHIFT-1:0] PhaseFetch = TILE_SHIFT'((1 << TILE_SHIFT) - 2);

  // Beam position decode
  logic [TILE_SHIFT-1:0] phase;
  logic [9:0]            col;
  logic [9:0]            row;
  logic [9:0]            next_y;
  logic [9:0]            next_row;

  assign phase    = pixel_x[TILE_SHIFT-1:0];
  assign col      = pixel_x >> TILE_SHIFT;
  assign row      = pixel_y >> TILE_SHIFT;
  assign next_y   = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y + 10'd1;
  assign next_row = next_y >> TILE_SHIFT;

  // Slot a fetches the next tile on this line; slot b fetches column 0 of the next line.
  logic              slot_a;
  logic              slot_b;
  logic              disp_slot;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] disp_addr;

  assign slot_a = (phase == PhaseFetch) && (col < 10'(MAP_W - 1)) &&
                  (pixel_y < 10'(V_ACTIVE));
  assign slot_b = (pixel_x == 10'(H_TOTAL - 2)) && (next_y < 10'(V_ACTIVE));
  assign disp_slot = slot_a | slot_b;

  assign addr_a    = ADDR_W'(row) * ADDR_W'(MAP_W) + ADDR_W'(col) + ADDR_W'(1);
  assign addr_b    = ADDR_W'(next_row) * ADDR_W'(MAP_W);
  assign disp_addr = slot_a ? addr_a : addr_b;

  // State
  logic [ADDR_W-1:0] ram_addr_q;
  logic              disp_pend_q;
  logic              rd_pend_q;
  logic              rd_oor_q;
  logic [DATA_W-1:0] tile_cur_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic game_in_range;
  logic gnt_rd;

  assign game_in_range = 32'(game.addr) < MapSize;

  // Arbitration decision
  always_comb begin
    game.gnt  = 1'b0;
    game.err  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = game.wdata;
    if (rst) begin
      ram_addr = '0;
    end else if (disp_slot) begin
      ram_addr = disp_addr;
    end else if (game.req) begin
      game.gnt = 1'b1;
      ram_addr = game.addr;
      ram_we   = game.we & game_in_range;
      game.err = ~game_in_range;
    end
  end

  assign gnt_rd = game.gnt & ~game.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q  <= '0;
      disp_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
      tile_cur_q  <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr;
      disp_pend_q <= disp_slot;
      rd_pend_q   <= gnt_rd;
      rd_oor_q    <= ~game_in_range;
      rvalid_q    <= rd_pend_q;
      // disp_pend always lands on the last phase of a tile, so the code flips on its boundary
      if (disp_pend_q) begin
        tile_cur_q <= ram_rdata;
      end
      if (rd_pend_q) begin
        rdata_q <= rd_oor_q ? '0 : ram_rdata;
      end
    end
  end

  assign tile_cur    = tile_cur_q;
  assign game.rdata  = rdata_q;
  assign game.rvalid = rvalid_q;

endmodule

// File: doc/map_ram_arbiter.md
# map_ram_arbiter

Shares the single-port, synchronous-read tile-map RAM of the PushBox board between the VGA display path and the game logic. It works from the `pixel_x`/`pixel_y` counters produced by `VGA_Scan`. It prefetches one tile code per 32-pixel tile so the renderer always sees the code of the tile under the beam. Game-logic reads and writes are granted in every remaining cycle.

## Interface
Parameters:
- `TILE_SHIFT`, 5: log2 of the tile edge in pixels (32×32 tiles).
- `MAP_W`, 20: tiles per row.
- `MAP_H`, 15: tile rows.
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines.
- `H_TOTAL`, 800: pixel_x period.
- `V_TOTAL`, 525: pixel_y period.
- `ADDR_W`, 9: map address width (row*MAP_W + col).
- `DATA_W`, 3: tile code width.

Ports:
- `clk` input, 1: pixel clock, shared with `VGA_Scan`.
- `rst` input, 1: synchronous, active-high reset.
- `pixel_x` input, 10: current column from `VGA_Scan`.
- `pixel_y` input, 10: current line from `VGA_Scan`.
- `tile_cur` output, DATA_W: tile code for the current pixel (registered).
- `game_req` input, 1: game access request; held high until granted.
- `game_we` input, 1: 1 = write, 0 = read; stable while `game_req`.
- `game_addr` input, ADDR_W: map address; stable while `game_req`.
- `game_wdata` input, DATA_W: write data.
- `game_gnt` output, 1: one-cycle grant pulse (combinational from the arbitration decision).
- `game_rdata` output, DATA_W: read data (registered).
- `game_rvalid` output, 1: one-cycle pulse qualifying `game_rdata`.
- `game_err` output, 1: one-cycle pulse when a granted address is ≥ MAP_W*MAP_H.
- `ram_addr` output, ADDR_W: RAM address (combinational).
- `ram_we` output, 1: RAM write enable (combinational).
- `ram_wdata` output, DATA_W: RAM write data.
- `ram_rdata` input, DATA_W: RAM read data, valid one cycle after the address is presented.

## Operation
Phase and tile coordinates:
- `phase = pixel_x[TILE_SHIFT-1:0]`, `col = pixel_x >> TILE_SHIFT`, `row = pixel_y >> TILE_SHIFT`.
- `next_y = (pixel_y == V_TOTAL-1) ? 0 : pixel_y+1`.

Display slot: a cycle is a display slot when either of the following holds.
- (a) `phase == 30`, `col < MAP_W-1`, `pixel_y < V_ACTIVE`. Read address = `row*MAP_W + col + 1`.
- (b) `pixel_x == H_TOTAL-2`, `next_y < V_ACTIVE`. Read address = `(next_y>>TILE_SHIFT)*MAP_W`.

Arbitration, every cycle:
- In a display slot, the display owns the RAM: `ram_we` = 0 and `game_gnt` = 0. Any game request waits.
- Otherwise, if `game_req` is high, `game_gnt` = 1 and `ram_addr` = `game_addr`.
  - `ram_we` = `game_we` only when `game_addr` < MAP_W*MAP_H.
  - An out-of-range address pulses `game_err` in the same cycle. There is no write, and a read returns 0.
- Otherwise the RAM is idle: `ram_we` = 0 and `ram_addr` holds its last value.

Capture:
- `disp_pend` is set in the cycle after a display slot.
- At the end of a `disp_pend` cycle, `tile_cur <= ram_rdata`. That cycle is `phase == 31`, so the new code is valid exactly from the first pixel of the next tile.
- `tile_cur` holds in all other cycles. It is not masked in blanking; the renderer gates with `video_out`.

Game reads:
- `rd_pend` is set in the cycle after a granted read.
- At the end of that cycle, `game_rdata <= ram_rdata`, or 0 if out of range.
- `game_rvalid` pulses in the following cycle.
- Writes produce no `rvalid`.

Reset: a reset mid-operation drops pending display and game reads; no `rvalid` is issued for them.

## Timing
Reset values:
- `tile_cur` = 0, `game_rdata` = 0, `game_rvalid` = 0, `game_err` = 0.
- `game_gnt` = 0 (forced low while `rst`).
- `ram_we` = 0, `ram_addr` = 0, `disp_pend` = 0, `rd_pend` = 0.

Game access latency:
- Request to grant: 0 cycles when not in a display slot, 1 cycle when in one. Display slots are never adjacent.
- Read grant (cycle G) to `game_rvalid` (cycle G+2).
- Write takes effect in the RAM at the end of cycle G.

Back-to-back requests: a new request may be presented in the cycle after its grant, giving one access per cycle outside display slots.

Display latency: slot at `phase` 30, RAM data in `phase` 31, `tile_cur` updated at the start of `phase` 0 of the next tile.

Wrap-around:
- Slot (b) at `pixel_x` = 798 loads column 0 for the next line, so `tile_cur` is correct at `pixel_x` = 0.
- When `pixel_y` = 524, `next_y` = 0 and row 0 is loaded.
- Slot (b) is suppressed when `next_y` ≥ 480.

Simultaneous events:
- A game request in a display slot is serviced in the next cycle.
- A write in the cycle immediately before a display slot to the address being prefetched is visible to that prefetch.

## Test plan
- Reset then release: hold `rst` for 10 cycles with `game_req` = 1. Require `game_gnt` = 0, `tile_cur` = 0, `ram_we` = 0 throughout reset, and the first grant in the first cycle after release.
- Display prefetch: preload RAM[k] = k mod 8 and run a full frame. Require `tile_cur` == RAM[row*20+col] at every pixel with x < 640, y < 480, including x = 0 of every line and line 0 after the frame wrap.
- Collision: assert a read of addr 45 on the cycle with `pixel_x` = 94 (`phase` 30), `pixel_y` = 40. Require `game_gnt` = 0 there and 1 at `pixel_x` = 95, `game_rvalid` at 97 with RAM[45], and `tile_cur` at `pixel_x` = 96 equal to RAM[23].
- Write then read back: write addr 299 = 5, then read 299 back-to-back. Require grants on consecutive cycles and `game_rdata` = 5 two cycles after the read grant.
- Out of range: write addr 300 = 7. Require a `game_gnt` and `game_err` pulse together, `ram_we` = 0, and RAM unchanged. A read of 511 returns `game_rdata` = 0 with `game_err` = 1.
- Reset mid-read: assert `rst` in the cycle after a read grant. Require no `game_rvalid` and `game_rdata` = 0.
